pc_seq_param: RTL and testbench

Parametrised program counter for the paper processor and the successor to the 2-bit JNO-driven counter. It generalises the counter to PC_W bits with a programmable step and reset vector. It adds a qualified jump on the open pulse, RUN/HALT control and a wrap indicator. An optional hardware call/return stack is available. The block sits between the control decoder (jump strobes, JNO address) and instruction memory (select).

---
 rtl/pc_seq_param.sv | 193 +++++++++++++++++++
 tb/tb_pc_seq_param.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_seq_param.sv
// -----------------------------------------------------------------------------
// pc_seq_param
//
// Parametrised program counter for the paper processor. It sits between the
// control decoder (jump strobes, JNO address) and instruction memory (select).
// Each clock edge selects exactly one action, highest priority first:
// halt request, return, call, qualified jump, increment by STEP, hold.
// A HALT state freezes the counter until resume is seen without halt_req.
//
// Optional feature macro: PC_RET_STACK_EN
//   defined   : STACK_DEPTH-entry LIFO of return addresses; call pushes
//               select+STEP and jumps to jno, ret pops into select.
//               Overflow/underflow set the sticky stack_err flag.
//   undefined : no stack storage. call is an unconditional jump to jno,
//               ret is ignored and stack_err is tied low.
//   The port list is identical in both builds.
//
// Parameters:
//   PC_W        counter / address width (>= 2)
//   STEP        increment per advance, taken modulo 2^PC_W
//   RESET_VEC   value loaded into select on reset
//   STACK_DEPTH return-stack entries (stack build only, >= 1)
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   en         in   advance enable (increment when nothing else happens)
//   openpulse  in   jump strobe from control
//   enabled    in   JNO jump qualifier
//   ovf        in   overflow flag, jump only taken while 0
//   jno        in   jump / call target address
//   halt_req   in   enter HALT
//   resume     in   leave HALT
//   call       in   call strobe
//   ret        in   return strobe
//   select     out  current program address (registered)
//   halted     out  1 while the state is HALT (this is the FSM state bit)
//   wrapped    out  one-cycle pulse when an increment carries out
//   stack_err  out  sticky push-when-full / pop-when-empty flag
// -----------------------------------------------------------------------------
module pc_seq_param #(
    parameter int          PC_W        = 4,
    parameter int unsigned STEP        = 1,
    parameter int unsigned RESET_VEC   = 0,
    parameter int          STACK_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic            openpulse,
    input  logic            enabled,
    input  logic            ovf,
    input  logic [PC_W-1:0] jno,
    input  logic            halt_req,
    input  logic            resume,
    input  logic            call,
    input  logic            ret,
    output logic [PC_W-1:0] select,
    output logic            halted,
    output logic            wrapped,
    output logic            stack_err
);

    localparam logic [PC_W-1:0] STEP_V  = PC_W'(STEP);
    localparam logic [PC_W-1:0] RESET_V = PC_W'(RESET_VEC);
    // A STEP of 2^PC_W or more always carries out of the unbounded sum,
    // even though only its low PC_W bits change the address.
    localparam bit STEP_OVER = ((STEP >> PC_W) != 0);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    state_t          r_state;
    logic [PC_W-1:0] r_select;
    logic            r_wrapped;

    logic [PC_W:0]   w_sum;
    logic            w_carry;
    logic            w_jump_take;

    assign w_sum       = {1'b0, r_select} + {1'b0, STEP_V};
    assign w_carry     = w_sum[PC_W] | STEP_OVER;
    assign w_jump_take = openpulse & enabled & ~ovf;

`ifdef PC_RET_STACK_EN
    localparam int PTR_W = $clog2(STACK_DEPTH + 1);
    localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam logic [PTR_W-1:0] PTR_FULL = PTR_W'(STACK_DEPTH);

    // r_ptr counts occupied entries; the top of stack is entry r_ptr-1.
    logic [PC_W-1:0]  r_stack [STACK_DEPTH];
    logic [PTR_W-1:0] r_ptr;
    logic             r_stack_err;

    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic [IDX_W-1:0] w_push_idx;
    logic [IDX_W-1:0] w_pop_idx;

    assign w_full     = (r_ptr == PTR_FULL);
    assign w_empty    = (r_ptr == '0);
    assign w_push_idx = IDX_W'(r_ptr);
    assign w_pop_idx  = IDX_W'(r_ptr - PTR_W'(1));

    // Same qualification as the call branch of the state machine below:
    // running, no halt request, ret not competing, and room on the stack.
    assign w_push = (r_state == ST_RUN) & ~halt_req & ~ret & call & ~w_full;

    // Stack contents are don't-care after reset, so the storage has no reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_stack[w_push_idx] <= w_sum[PC_W-1:0];
        end
    end

    assign stack_err = r_stack_err;
`else
    localparam int UNUSED_STACK_DEPTH = STACK_DEPTH;
    logic w_unused_ret;
    assign w_unused_ret = ret;
    assign stack_err    = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_RUN;
            r_select  <= RESET_V;
            r_wrapped <= 1'b0;
`ifdef PC_RET_STACK_EN
            r_ptr       <= '0;
            r_stack_err <= 1'b0;
`endif
        end else begin
            // wrapped is a pulse: only the carrying increment raises it.
            r_wrapped <= 1'b0;
            case (r_state)
                ST_RUN: begin
                    if (halt_req) begin
                        r_state <= ST_HALT;
                    end
`ifdef PC_RET_STACK_EN
                    else if (ret) begin
                        // ret beats call; an empty pop leaves select alone.
                        if (w_empty) begin
                            r_stack_err <= 1'b1;
                        end else begin
                            r_select <= r_stack[w_pop_idx];
                            r_ptr    <= r_ptr - PTR_W'(1);
                        end
                    end
                    else if (call) begin
                        // A full stack drops the push but the jump still happens.
                        if (w_full) begin
                            r_stack_err <= 1'b1;
                        end else begin
                            r_ptr <= r_ptr + PTR_W'(1);
                        end
                        r_select <= jno;
                    end
`else
                    else if (call) begin
                        r_select <= jno;
                    end
`endif
                    else if (w_jump_take) begin
                        r_select <= jno;
                    end
                    else if (en) begin
                        r_select  <= w_sum[PC_W-1:0];
                        r_wrapped <= w_carry;
                    end
                end
                ST_HALT: begin
                    // halt_req wins over resume; leaving HALT does not move select.
                    if (resume && !halt_req) begin
                        r_state <= ST_RUN;
                    end
                end
                default: begin
                    r_state <= ST_RUN;
                end
            endcase
        end
    end

    assign select  = r_select;
    assign halted  = (r_state == ST_HALT);
    assign wrapped = r_wrapped;

endmodule

// File: tb/tb_pc_seq_param.sv
// -----------------------------------------------------------------------------
// tb_pc_seq_param
//
// Two instances of pc_seq_param share clock and reset:
//   dut_a : PC_W=4, STEP=1, RESET_VEC=0, STACK_DEPTH=2
//   dut_b : PC_W=3, STEP=3, RESET_VEC=2, STACK_DEPTH=2
// A behavioural model tracks address, halt, wrap, error and a return stack
// per instance with plain integer arithmetic. Directed sequences pin the
// model with literal values, then random traffic (including asynchronous
// resets) is compared against the model on every falling clock edge.
// -----------------------------------------------------------------------------
module tb_pc_seq_param;

    typedef struct packed {
        logic       en;
        logic       openpulse;
        logic       enabled;
        logic       ovf;
        logic       halt_req;
        logic       resume;
        logic       call;
        logic       ret;
        logic [3:0] jno;
    } in_t;

`ifdef PC_RET_STACK_EN
    localparam bit HAS_STK = 1'b1;
`else
    localparam bit HAS_STK = 1'b0;
`endif
    localparam int TB_DEPTH = 2;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst_n;
    logic chk_on;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUTs ----------------
    in_t        in_a;
    in_t        in_b;
    logic [3:0] a_select;
    logic       a_halted, a_wrapped, a_err;
    logic [2:0] b_select;
    logic       b_halted, b_wrapped, b_err;

    pc_seq_param #(.PC_W(4), .STEP(1), .RESET_VEC(0), .STACK_DEPTH(TB_DEPTH)) dut_a (
        .clk(clk), .rst_n(rst_n), .en(in_a.en), .openpulse(in_a.openpulse),
        .enabled(in_a.enabled), .ovf(in_a.ovf), .jno(in_a.jno),
        .halt_req(in_a.halt_req), .resume(in_a.resume), .call(in_a.call),
        .ret(in_a.ret), .select(a_select), .halted(a_halted),
        .wrapped(a_wrapped), .stack_err(a_err)
    );

    pc_seq_param #(.PC_W(3), .STEP(3), .RESET_VEC(2), .STACK_DEPTH(TB_DEPTH)) dut_b (
        .clk(clk), .rst_n(rst_n), .en(in_b.en), .openpulse(in_b.openpulse),
        .enabled(in_b.enabled), .ovf(in_b.ovf), .jno(in_b.jno[2:0]),
        .halt_req(in_b.halt_req), .resume(in_b.resume), .call(in_b.call),
        .ret(in_b.ret), .select(b_select), .halted(b_halted),
        .wrapped(b_wrapped), .stack_err(b_err)
    );

    // ---------------- scoreboard counters ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int m_w    [2] = '{4, 3};
    int m_step [2] = '{1, 3};
    int m_rv   [2] = '{0, 2};
    int m_sel  [2];
    int m_halt [2];
    int m_wrap [2];
    int m_err  [2];
    int m_sp   [2];
    int m_stk  [2][8];

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_sel[k]  = m_rv[k];
            m_halt[k] = 0;
            m_wrap[k] = 0;
            m_err[k]  = 0;
            m_sp[k]   = 0;
        end
    endtask

    task automatic model_step(input int k, input in_t x);
        int md;
        int sum;
        md = 1 << m_w[k];
        sum = m_sel[k] + m_step[k];
        m_wrap[k] = 0;
        if (m_halt[k] != 0) begin
            if (x.resume && !x.halt_req) m_halt[k] = 0;
        end else if (x.halt_req) begin
            m_halt[k] = 1;
        end else if (HAS_STK && x.ret) begin
            if (m_sp[k] == 0) begin
                m_err[k] = 1;
            end else begin
                m_sp[k]  = m_sp[k] - 1;
                m_sel[k] = m_stk[k][m_sp[k]];
            end
        end else if (x.call) begin
            if (HAS_STK) begin
                if (m_sp[k] == TB_DEPTH) begin
                    m_err[k] = 1;
                end else begin
                    m_stk[k][m_sp[k]] = sum % md;
                    m_sp[k] = m_sp[k] + 1;
                end
            end
            m_sel[k] = int'(x.jno) % md;
        end else if (x.openpulse && x.enabled && !x.ovf) begin
            m_sel[k] = int'(x.jno) % md;
        end else if (x.en) begin
            m_wrap[k] = (sum >= md) ? 1 : 0;
            m_sel[k]  = sum % md;
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            model_reset();
        end else begin
            model_step(0, in_a);
            model_step(1, in_b);
        end
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (chk_on) begin
            check("a_select",  {28'd0, a_select}, m_sel[0]);
            check("a_halted",  {31'd0, a_halted}, m_halt[0]);
            check("a_wrapped", {31'd0, a_wrapped}, m_wrap[0]);
            check("a_stack_err", {31'd0, a_err}, m_err[0]);
            check("b_select",  {29'd0, b_select}, m_sel[1]);
            check("b_halted",  {31'd0, b_halted}, m_halt[1]);
            check("b_wrapped", {31'd0, b_wrapped}, m_wrap[1]);
            check("b_stack_err", {31'd0, b_err}, m_err[1]);
        end
    end

    // ---------------- driver helpers ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic in_t mk(input logic en_i, input logic op_i, input logic enab_i,
                               input logic ovf_i, input logic halt_i, input logic res_i,
                               input logic call_i, input logic ret_i, input int jno_i);
        in_t v;
        v.en = en_i; v.openpulse = op_i; v.enabled = enab_i; v.ovf = ovf_i;
        v.halt_req = halt_i; v.resume = res_i; v.call = call_i; v.ret = ret_i;
        v.jno = 4'(jno_i);
        return v;
    endfunction

    task automatic drive_a(input in_t v);
        in_a = v;
        cyc();
    endtask

    task automatic lit_a(input string tag, input int sel, input int h, input int w, input int e);
        check({tag, "_select"}, {28'd0, a_select}, sel);
        check({tag, "_halted"}, {31'd0, a_halted}, h);
        check({tag, "_wrapped"}, {31'd0, a_wrapped}, w);
        check({tag, "_stack_err"}, {31'd0, a_err}, e);
    endtask

    function automatic in_t rnd_in();
        in_t v;
        v.en        = ($urandom_range(0, 3) != 0);
        v.openpulse = ($urandom_range(0, 2) == 0);
        v.enabled   = ($urandom_range(0, 1) == 1);
        v.ovf       = ($urandom_range(0, 2) == 0);
        v.halt_req  = ($urandom_range(0, 15) == 0);
        v.resume    = ($urandom_range(0, 3) == 0);
        v.call      = ($urandom_range(0, 7) == 0);
        v.ret       = ($urandom_range(0, 7) == 0);
        v.jno       = 4'($urandom_range(0, 15));
        return v;
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        int b_exp_sel [5] = '{5, 0, 3, 6, 1};
        int b_exp_wr  [5] = '{0, 1, 0, 0, 1};

        chk_on = 1'b0;
        in_a   = '0;
        in_b   = '0;
        rst_n  = 1'b1;
        #1 rst_n = 1'b0;
        #1 chk_on = 1'b1;
        lit_a("reset", 0, 0, 0, 0);
        check("reset_b_select", {29'd0, b_select}, 2);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // dut_b: STEP=3 on a 3-bit counter from 2.
        in_b.en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cyc();
            check("b_seq_select", {29'd0, b_select}, b_exp_sel[i]);
            check("b_seq_wrapped", {31'd0, b_wrapped}, b_exp_wr[i]);
        end
        in_b = '0;

        // dut_a: full count 0..15 then 0 with a single wrap pulse.
        in_a.en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            cyc();
            check("count_select", {28'd0, a_select}, (i + 1) % 16);
            check("count_wrapped", {31'd0, a_wrapped}, (i == 15) ? 1 : 0);
        end
        cyc();
        lit_a("after_wrap", 1, 0, 0, 0);

        // Asynchronous reset mid-count, checked well before the next edge.
        #2 rst_n = 1'b0;
        #1;
        lit_a("async_reset", 0, 0, 0, 0);
        check("async_reset_b", {29'd0, b_select}, 2);
        in_a = '0;
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Qualified jump and its fall-through cases.
        in_a.en = 1'b1;
        repeat (5) cyc();
        lit_a("at5", 5, 0, 0, 0);
        drive_a(mk(0, 1, 1, 0, 0, 0, 0, 0, 12));
        lit_a("jump_taken", 12, 0, 0, 0);
        drive_a(mk(0, 1, 1, 0, 0, 0, 0, 0, 5));
        lit_a("jump_back", 5, 0, 0, 0);
        drive_a(mk(1, 1, 1, 1, 0, 0, 0, 0, 12));
        lit_a("jump_ovf", 6, 0, 0, 0);
        drive_a(mk(1, 1, 0, 0, 0, 0, 0, 0, 12));
        lit_a("jump_disabled", 7, 0, 0, 0);

        // HALT behaviour.
        drive_a(mk(1, 0, 0, 0, 1, 0, 0, 0, 0));
        lit_a("halt_enter", 7, 1, 0, 0);
        drive_a(mk(1, 1, 1, 0, 0, 0, 1, 0, 3));
        lit_a("halt_ignore", 7, 1, 0, 0);
        drive_a(mk(1, 0, 0, 0, 1, 1, 0, 0, 0));
        lit_a("halt_and_resume", 7, 1, 0, 0);
        drive_a(mk(1, 0, 0, 0, 0, 1, 0, 0, 0));
        lit_a("resume", 7, 0, 0, 0);
        drive_a(mk(1, 0, 0, 0, 0, 0, 0, 0, 0));
        lit_a("after_resume", 8, 0, 0, 0);
        drive_a(mk(0, 1, 1, 0, 0, 0, 0, 0, 3));
        lit_a("to3", 3, 0, 0, 0);

`ifdef PC_RET_STACK_EN
        drive_a(mk(0, 0, 0, 0, 0, 0, 1, 0, 9));
        lit_a("call1", 9, 0, 0, 0);
        drive_a(mk(0, 0, 0, 0, 0, 0, 1, 0, 14));
        lit_a("call2", 14, 0, 0, 0);
        drive_a(mk(0, 0, 0, 0, 0, 0, 1, 0, 1));
        lit_a("call_full", 1, 0, 0, 1);
        // The third push was dropped, so the stack holds 4 and 10.
        drive_a(mk(0, 0, 0, 0, 0, 0, 0, 1, 0));
        lit_a("ret1", 10, 0, 0, 1);
        drive_a(mk(0, 0, 0, 0, 0, 0, 0, 1, 0));
        lit_a("ret2", 4, 0, 0, 1);
        drive_a(mk(0, 0, 0, 0, 0, 0, 0, 1, 0));
        lit_a("ret_empty", 4, 0, 0, 1);
        drive_a(mk(0, 0, 0, 0, 0, 0, 1, 1, 7));
        lit_a("call_ret_both", 4, 0, 0, 1);
`else
        drive_a(mk(0, 0, 0, 1, 0, 0, 1, 0, 10));
        lit_a("call_nostack", 10, 0, 0, 0);
        drive_a(mk(0, 0, 0, 0, 0, 0, 0, 1, 0));
        lit_a("ret_nostack", 10, 0, 0, 0);
        drive_a(mk(0, 0, 0, 0, 0, 0, 1, 1, 7));
        lit_a("call_ret_nostack", 7, 0, 0, 0);
`endif

        // Random traffic on both instances, with occasional async resets.
        for (int n = 0; n < 3000; n++) begin
            in_a = rnd_in();
            in_b = rnd_in();
            cyc();
            if ($urandom_range(0, 199) == 0) begin
                #2 rst_n = 1'b0;
                #4 rst_n = 1'b1;
            end
        end

        in_a = '0;
        in_b = '0;
        cyc();
        cyc();
        chk_on = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
